mult_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 16x16 signed radix-8 Booth multiplier among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, registers its operands, registers the 32-bit product, and returns it with the requester index through a single valid/ready result port. It sits between client engines and the multiplier datapath, and it instantiates that datapath internally.

---
 rtl/mult_share_arb.sv | 139 +++++++++++++
 tb/tb_mult_share_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// Round-robin share of one radix-8 Booth 16x16 signed multiplier among NREQ requesters; optional MULT_SHARE_ARB_STALL_CNT_EN adds stall_cnt.
// Latency: operands accepted at edge T, res_valid high from edge T+1; one transaction in flight, issue every 3 cycles at best.
// Backpressure: res_ready=0 holds the result in RESP and blocks all grants; req_ready is combinational on req_valid.
module mult_share_arb #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [IDW-1:0]    res_id
`ifdef MULT_SHARE_ARB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, op_id, gnt_id, idx;
  logic           gnt_vld;
  logic [15:0]    op_a, op_b, sel_a, sel_b;
  logic [31:0]    product;

  // Partial products use digits -4..4 over 6 overlapping 4-bit groups of b.
  function automatic logic [31:0] booth_mul(input logic [15:0] a, input logic [15:0] b);
    logic [18:0] bx;
    logic [31:0] a1, a3, pp, acc;
    bx  = {b[15], b[15], b, 1'b0};
    a1  = {{16{a[15]}}, a};
    a3  = a1 + (a1 << 1);
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      case (bx[3*i +: 4])
        4'b0000, 4'b1111: pp = '0;
        4'b0001, 4'b0010: pp = a1;
        4'b0011, 4'b0100: pp = a1 << 1;
        4'b0101, 4'b0110: pp = a3;
        4'b0111:          pp = a1 << 2;
        4'b1000:          pp = -(a1 << 2);
        4'b1001, 4'b1010: pp = -a3;
        4'b1011, 4'b1100: pp = -(a1 << 1);
        default:          pp = -a1;
      endcase
      acc = acc + (pp << (3*i));
    end
    return acc;
  endfunction

  assign product = booth_mul(op_a, op_b);

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_id == IDW'(j)) begin
        sel_a = req_a[16*j +: 16];
        sel_b = req_b[16*j +: 16];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && gnt_vld)
      req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = MUL;
      MUL:     state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          op_a   <= sel_a;
          op_b   <= sel_b;
          op_id  <= gnt_id;
          rr_ptr <= gnt_id + IDW'(1);
        end
        MUL: begin
          res_data  <= product;
          res_id    <= op_id;
          res_valid <= 1'b1;
        end
        RESP: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MULT_SHARE_ARB_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (res_valid && !res_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: vector table of products plus round-robin, wrap, backpressure and reset corners.
module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [16*NREQ-1:0] req_a = '0;
  logic [16*NREQ-1:0] req_b = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [31:0]       res_data;
  logic [IDW-1:0]    res_id;
`ifdef MULT_SHARE_ARB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mult_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
`ifdef MULT_SHARE_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int p);
    return 4'b0001 << p;
  endfunction

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    return 32'($signed(a) * $signed(b));
  endfunction

  task automatic set_ops(input int p, input logic [15:0] a, input logic [15:0] b);
    req_a[16*p +: 16] = a;
    req_b[16*p +: 16] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Starts just after a posedge in IDLE with requests driven; ends just after the edge back into IDLE.
  task automatic serve(input string name, input int g, input logic [31:0] exp, input bit drop);
    @(negedge clk);
    chk({name, " grant"}, 32'(req_ready), 32'(oh(g)));
    @(posedge clk);
    #1 if (drop) req_valid[g] = 1'b0;
    @(negedge clk);
    chk({name, " mul no ready/valid"}, {30'd0, req_ready != 0, res_valid}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, " res_valid"}, 32'(res_valid), 32'd1);
    chk({name, " res_data"}, res_data, exp);
    chk({name, " res_id"}, 32'(res_id), 32'(g));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{0, 16'hFFFD, 16'h0007, 32'hFFFFFFEB};
    vecs[1]  = '{1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[2]  = '{2, 16'h8000, 16'h8000, 32'h40000000};
    vecs[3]  = '{3, 16'h8000, 16'h0001, 32'hFFFF8000};
    vecs[4]  = '{0, 16'h0000, 16'h1234, 32'h00000000};
    vecs[5]  = '{1, 16'h1234, 16'h0010, 32'h00012340};
    vecs[6]  = '{2, 16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[7]  = '{3, 16'h0003, 16'h8000, 32'hFFFE8000};
    vecs[8]  = '{0, 16'h00FF, 16'h0101, 32'h0000FFFF};
    vecs[9]  = '{1, 16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[10] = '{2, 16'h0007, 16'hFFF9, 32'hFFFFFFCF};
    vecs[11] = '{3, 16'h1111, 16'h0003, 32'h00003333};

    // Reset values, with every requester asking.
    req_valid = 4'b1111;
    #2;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset res_data", res_data, 32'd0);
    chk("reset res_id", 32'(res_id), 32'd0);
    req_valid = '0;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      set_ops(vecs[i].port, vecs[i].a, vecs[i].b);
      req_valid = oh(vecs[i].port);
      serve($sformatf("vec%0d", i), vecs[i].port, vecs[i].exp, 1'b1);
    end

    // Round robin with all four holding requests.
    do_reset();
    for (int p = 0; p < NREQ; p++) set_ops(p, 16'(p * 257 + 3), 16'(-(p * 3 + 5)));
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++)
      serve($sformatf("rr%0d", n), n % 4, model(16'((n % 4) * 257 + 3), 16'(-((n % 4) * 3 + 5))), 1'b0);
    req_valid = '0;
    @(posedge clk);
    #1;

    // Wrap and skip: rr_ptr=3, requests 0101 -> 0 then 2, leaving rr_ptr=3.
    do_reset();
    set_ops(2, 16'd5, 16'd6);
    req_valid = 4'b0100;
    serve("wrap pre", 2, 32'd30, 1'b1);
    set_ops(0, 16'hFFF0, 16'h0010);
    set_ops(2, 16'h0100, 16'h0100);
    req_valid = 4'b0101;
    serve("wrap g0", 0, 32'hFFFFFF00, 1'b1);
    serve("wrap g2", 2, 32'h00010000, 1'b1);
    req_valid = 4'b1111;
    @(negedge clk);
    chk("wrap ptr3", 32'(req_ready), 32'(oh(3)));
    req_valid = '0;
    @(posedge clk);
    #1;

    // Backpressure: 5 stalled cycles in RESP.
    do_reset();
    res_ready = 1'b0;
    set_ops(1, 16'h0123, 16'h0045);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp grant", 32'(req_ready), 32'(oh(1)));
    @(posedge clk);
    #1 req_valid = 4'b1111;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d res_valid", k), 32'(res_valid), 32'd1);
      chk($sformatf("bp%0d res_data", k), res_data, 32'h00004E6F);
      chk($sformatf("bp%0d res_id", k), 32'(res_id), 32'd1);
      chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bp still valid", 32'(res_valid), 32'd1);
`ifdef MULT_SHARE_ARB_STALL_CNT_EN
    chk("bp stall_cnt", 32'(stall_cnt), 32'd5);
`endif
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp released", 32'(res_valid), 32'd0);
    chk("bp next grant", 32'(req_ready), 32'(oh(2)));
    req_valid = '0;
    @(posedge clk);
    #1;

    // Reset during MUL discards the transaction and clears rr_ptr.
    do_reset();
    set_ops(2, 16'd9, 16'd9);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rst grant2", 32'(req_ready), 32'(oh(2)));
    @(posedge clk);
    #1;
    set_ops(1, 16'hFFFE, 16'h0003);
    set_ops(3, 16'h0002, 16'h0002);
    req_valid = 4'b1010;
    rst = 1'b1;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst no result", 32'(res_valid), 32'd0);
    chk("rst res_data", res_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    serve("post rst", 1, 32'hFFFFFFFA, 1'b1);
    @(negedge clk);
    chk("post rst next", 32'(req_ready), 32'(oh(3)));
    req_valid = '0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
